// File: rtl/regwb_arbiter.sv
// Round-robin arbiter for register-file write-back among 7 sources.
// One registered grant per WRITE cycle; back-to-back grants when others are pending.
module regwb_arbiter #(
  parameter int ZERO_SUPPRESS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  req,
  input  logic [34:0] dest,
  input  logic        hold,
  output logic [2:0]  mem_to_reg,
  output logic        reg_write,
  output logic [4:0]  write_reg,
  output logic [6:0]  ack,
  output logic        busy
);
  typedef enum logic {IDLE, WRITE} state_t;

  state_t           state, next_state;
  logic [2:0]       ptr, win;
  logic [2:0]       base, pick;
  logic [6:0]       cand;
  logic             found, grant;
  logic [6:0][4:0]  dest_v;
  logic [4:0]       dest_sel;
  logic [3:0]       sum;

  assign dest_v   = dest;
  assign dest_sel = dest_v[pick];

  // In WRITE the search starts at the pointer the current grant will leave behind,
  // and the current winner (still holding req) is excluded.
  always_comb begin
    base  = (state == WRITE) ? ((win == 3'd6) ? 3'd0 : win + 3'd1) : ptr;
    cand  = req;
    if (state == WRITE) cand[win] = 1'b0;
    found = 1'b0;
    pick  = 3'd0;
    sum   = 4'd0;
    for (int k = 0; k < 7; k++) begin
      sum = {1'b0, base} + 4'(k);
      if (sum >= 4'd7) sum = sum - 4'd7;
      if (!found && cand[sum[2:0]]) begin
        found = 1'b1;
        pick  = sum[2:0];
      end
    end
    grant = found && !hold;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant) next_state = WRITE;
      WRITE:   if (!grant) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr        <= 3'd0;
      win        <= 3'd0;
      mem_to_reg <= 3'd0;
      write_reg  <= 5'd0;
      reg_write  <= 1'b0;
      ack        <= 7'd0;
      busy       <= 1'b0;
    end else begin
      if (state == WRITE) ptr <= base;
      if (grant) begin
        win        <= pick;
        mem_to_reg <= pick;
        write_reg  <= dest_sel;
        ack        <= 7'd1 << pick;
        reg_write  <= !((ZERO_SUPPRESS != 0) && (dest_sel == 5'd0));
        busy       <= 1'b1;
      end else begin
        ack        <= 7'd0;
        reg_write  <= 1'b0;
        busy       <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_regwb_arbiter.sv
// Scoreboard bench for regwb_arbiter: expected grants queued at stimulus time,
// popped when ack appears; requesters drop req the cycle after their ack.
module tb_regwb_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  req = '0;
  logic [34:0] dest = '0;
  logic        hold = 1'b0;
  logic [2:0]  mem_to_reg, mem_to_reg_nz;
  logic        reg_write, reg_write_nz;
  logic [4:0]  write_reg, write_reg_nz;
  logic [6:0]  ack, ack_nz;
  logic        busy, busy_nz;

  regwb_arbiter #(.ZERO_SUPPRESS(1)) u_dut (
    .clk(clk), .reset(reset), .req(req), .dest(dest), .hold(hold),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .write_reg(write_reg),
    .ack(ack), .busy(busy));

  regwb_arbiter #(.ZERO_SUPPRESS(0)) u_nz (
    .clk(clk), .reset(reset), .req(req), .dest(dest), .hold(hold),
    .mem_to_reg(mem_to_reg_nz), .reg_write(reg_write_nz), .write_reg(write_reg_nz),
    .ack(ack_nz), .busy(busy_nz));

  always #5 clk = ~clk;

  typedef struct { int src; int dst; int rw; } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  logic [6:0] drop = '0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int s, input int d);
    exp_t e;
    dest[s*5 +: 5] = 5'(d);
    e.src = s; e.dst = d; e.rw = (d != 0) ? 1 : 0;
    sb.push_back(e);
  endtask

  // One clock: apply pending req drops after the edge, then inspect outputs mid-cycle.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    req  = req & ~drop;
    drop = '0;
    @(negedge clk);
    if (ack != 7'd0) begin
      if (sb.size() == 0) chk("unexpected_ack", int'(ack), 0);
      else begin
        e = sb.pop_front();
        chk("src", int'(mem_to_reg), e.src);
        chk("wreg", int'(write_reg), e.dst);
        chk("rw", int'(reg_write), e.rw);
        chk("ack_onehot", int'(ack), 1 << e.src);
        chk("busy_w", int'(busy), 1);
      end
      drop = ack;
    end else begin
      chk("idle_rw", int'(reg_write), 0);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; hold = 1'b0; drop = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    // reset state (async, before any clock edge)
    #3;
    chk("rst_rw", int'(reg_write), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_m2r", int'(mem_to_reg), 0);
    chk("rst_wreg", int'(write_reg), 0);
    do_reset();

    // single request, one-cycle latency; leaves ptr=2
    push(1, 8);
    req = 7'b0000010;
    step();
    chk("lat_ack", int'(ack), 2);
    run(3);
    chk("sb_single", sb.size(), 0);

    // ptr=2 must favour source 2 over source 0
    push(2, 9); push(0, 3);
    req = 7'b0000101;
    run(4);
    chk("sb_ptr2", sb.size(), 0);

    // full round-robin from ptr=0, one grant per cycle
    do_reset();
    for (int i = 0; i < 7; i++) push(i, 10 + i);
    req = 7'b1111111;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("rr_busy", int'(busy), 1);
    end
    run(2);
    chk("sb_rr", sb.size(), 0);

    // zero destination: ack without write unless suppression disabled
    push(3, 0);
    req = 7'b0001000;
    step();
    chk("zero_ack", int'(ack), 8);
    chk("zs0_rw", int'(reg_write_nz), 1);
    run(3);
    chk("sb_zero", sb.size(), 0);

    // hold blocks grants; release gives 0 then 4
    do_reset();
    hold = 1'b1;
    req = 7'b0010001;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold_ack", int'(ack), 0);
    end
    push(0, 4); push(4, 6);
    hold = 1'b0;
    run(4);
    chk("sb_hold", sb.size(), 0);

    // hold raised during WRITE: current write finishes, next waits (ptr 5 -> grant 1)
    push(1, 12); push(2, 13);
    req = 7'b0000110;
    step();
    hold = 1'b1;
    step();
    chk("holdw_ack", int'(ack), 0);
    chk("holdw_busy", int'(busy), 0);
    hold = 1'b0;
    run(4);
    chk("sb_holdw", sb.size(), 0);

    // wrap-around: grant 5 leaves ptr=6, then 0 wins over 1
    push(5, 20);
    req = 7'b0100000;
    run(3);
    push(0, 21); push(1, 22);
    req = 7'b0000011;
    run(4);
    chk("sb_wrap", sb.size(), 0);

    // async reset mid-write
    push(3, 5);
    req = 7'b0001000;
    step();
    chk("pre_rst_ack", int'(ack), 8);
    #1 reset = 1'b1;
    #1;
    chk("arst_rw", int'(reg_write), 0);
    chk("arst_ack", int'(ack), 0);
    chk("arst_busy", int'(busy), 0);
    req = '0; drop = '0;
    @(posedge clk);
    #1 reset = 1'b0;
    push(0, 7); push(6, 11);
    req = 7'b1000001;
    run(5);
    chk("sb_arst", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regwb_arbiter.md
REGWB_ARBITER -- requirements
Module: regwb_arbiter

Interface
REQ-001 Parameter: ZERO_SUPPRESS, default 1, meaning: when 1, a write whose destination is register 0 is acknowledged but reg_write stays 0.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-004 Port: req  in  7  per-source write request; bit i corresponds to mux data input i (selector value i).
REQ-005 Port: dest  in  35  packed destination register numbers; dest[5i+4:5i] belongs to source i.
REQ-006 Port: hold  in  1  blocks new grants while high; does not abort a write in progress.
REQ-007 Port: mem_to_reg  out  3  write-data mux selector; binary index of the granted source.
REQ-008 Port: reg_write  out  1  register-file write enable.
REQ-009 Port: write_reg  out  5  register-file destination number.
REQ-010 Port: ack  out  7  one-hot, one-cycle acknowledge to the granted source.
REQ-011 Port: busy  out  1  high while in state WRITE.

Function
REQ-012 Two states, IDLE and WRITE; all outputs are registered and driven from state and a 3-bit round-robin pointer ptr (range 0..6).
REQ-013 IDLE: if hold=0 and any req bit is 1, pick winner = first set req bit searching ptr, ptr+1, ... modulo 7; latch winner and dest of winner; go to WRITE next edge. Otherwise stay IDLE.
REQ-014 WRITE (exactly one cycle): mem_to_reg=winner, write_reg=latched dest, ack[winner]=1, busy=1, reg_write=1 except as REQ-015.
REQ-015 If ZERO_SUPPRESS=1 and latched dest=0: reg_write=0 in WRITE; ack still pulses.
REQ-016 On leaving WRITE: ptr = (winner+1) mod 7.
REQ-017 Back-to-back: in WRITE, if hold=0 and any req bit other than winner is 1, the next winner is chosen by REQ-013 using the updated ptr, excluding the current winner bit; state stays WRITE. Otherwise go IDLE.
REQ-018 Throughput: with continuous competing requests, one write per cycle; a single requester gets one write per two cycles (request sampled in IDLE, written in WRITE).
REQ-019 Latency: req rising at edge N (sampled at N+1 in IDLE) -> reg_write/ack high during cycle after edge N+1.
REQ-020 Requesters hold req and dest stable until ack; they drop req in the cycle following ack. req deasserted before ack is ignored if not yet latched; once latched, the write completes.
REQ-021 hold rising during WRITE: current write completes; next state IDLE; no grant while hold=1.
REQ-022 In IDLE: reg_write=0, ack=0, busy=0; mem_to_reg and write_reg keep their last values.
REQ-023 Values 7 of mem_to_reg are never produced.
REQ-024 ack never has more than one bit set; reg_write never high outside WRITE.

Reset
REQ-025 reset=1: state=IDLE, ptr=0, mem_to_reg=0, write_reg=0, reg_write=0, ack=0, busy=0, latched winner=0.
REQ-026 Reset asserted during WRITE aborts the write immediately (reg_write drops without waiting for clk); no ack is owed afterwards.
REQ-027 First grant after reset release favours source 0 when it is requesting.

Verification
REQ-028 Single request: req=0b0000010, dest[9:5]=8 -> one cycle later mem_to_reg=1, write_reg=8, reg_write=1, ack=0b0000010; then IDLE, ptr=2.
REQ-029 Round-robin: req=0b1111111 held (each dropped after own ack) from ptr=0 -> grants in order 0,1,2,3,4,5,6 on consecutive cycles, busy high throughout.
REQ-030 Zero register: source 3 requests dest=0 -> ack=0b0001000, reg_write=0; with ZERO_SUPPRESS=0 reg_write=1.
REQ-031 Hold: hold=1 with req=0b0010001 -> no ack for any number of cycles; hold released -> source 0 granted next, then source 4.
REQ-032 Async reset mid-write: assert reset between edges in WRITE -> reg_write, ack, busy go 0 before next edge; after release, req=0b1000000 -> grant source 6 with ptr starting at 0.
REQ-033 Wrap-around: ptr=6 after granting source 5, req=0b0000011 -> source 0 granted, ptr becomes 1.
